// File: rtl/fetch_stage.sv
// Instruction fetch front end: one outstanding memory request, 2-entry {pc, instr}
// buffer toward decode, and redirect handling that discards a response already in flight.
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_req_o,
  input  logic        dec_ack_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FLUSH_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_addr;
  logic        r_flush_pending;
  logic        w_flush_pending_next;
  logic        r_instr_req;
  logic        r_dec_req;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;
  logic        w_push;
  logic        w_pop;
  logic [31:0] r_fifo_pc    [0:1];
  logic [31:0] r_fifo_instr [0:1];

  // A redirect cancels both the buffer write and the decode handshake of its cycle.
  assign w_push = (r_state == S_WAIT) && instr_rvalid_i && !redirect_i;
  assign w_pop  = (r_count != 2'd0) && dec_ack_i && !redirect_i;

  always_comb begin
    if (redirect_i) begin
      w_count_next = 2'd0;
    end else begin
      w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_flush_pending_next = r_flush_pending;
    w_pc_next            = r_pc;
    if (redirect_i) begin
      w_pc_next = redirect_pc_i & ~32'h0000_0003;
    end
    case (r_state)
      S_IDLE: begin
        if (redirect_i || (r_count < 2'd2)) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (instr_gnt_i) begin
          w_flush_pending_next = 1'b0;
          if (redirect_i || r_flush_pending) begin
            w_state_next = S_FLUSH_WAIT;
          end else begin
            w_state_next = S_WAIT;
            w_pc_next    = r_addr + 32'd4;
          end
        end else if (redirect_i) begin
          // Address must stay stable until granted; the response is dropped later.
          w_flush_pending_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (instr_rvalid_i) begin
          if (redirect_i || (w_count_next < 2'd2)) begin
            w_state_next = S_REQ;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (redirect_i) begin
          w_state_next = S_FLUSH_WAIT;
        end
      end
      S_FLUSH_WAIT: begin
        if (instr_rvalid_i) begin
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_pc            <= BOOT_ADDR;
      r_addr          <= BOOT_ADDR;
      r_flush_pending <= 1'b0;
      r_instr_req     <= 1'b0;
      r_dec_req       <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_flush_pending <= w_flush_pending_next;
      r_instr_req     <= (w_state_next == S_REQ);
      r_dec_req       <= (w_count_next != 2'd0);
      r_count         <= w_count_next;
      if ((w_state_next == S_REQ) && (r_state != S_REQ)) begin
        r_addr <= w_pc_next;
      end
    end
  end

  // Shift-style buffer: entry 0 is always the head, so decode outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fifo_pc[0]    <= 32'd0;
      r_fifo_pc[1]    <= 32'd0;
      r_fifo_instr[0] <= 32'd0;
      r_fifo_instr[1] <= 32'd0;
    end else if (w_push && w_pop) begin
      if (r_count == 2'd1) begin
        r_fifo_pc[0]    <= r_addr;
        r_fifo_instr[0] <= instr_rdata_i;
      end else begin
        r_fifo_pc[0]    <= r_fifo_pc[1];
        r_fifo_instr[0] <= r_fifo_instr[1];
        r_fifo_pc[1]    <= r_addr;
        r_fifo_instr[1] <= instr_rdata_i;
      end
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_fifo_pc[0]    <= r_addr;
        r_fifo_instr[0] <= instr_rdata_i;
      end else begin
        r_fifo_pc[1]    <= r_addr;
        r_fifo_instr[1] <= instr_rdata_i;
      end
    end else if (w_pop) begin
      r_fifo_pc[0]    <= r_fifo_pc[1];
      r_fifo_instr[0] <= r_fifo_instr[1];
    end
  end

  assign instr_req_o  = r_instr_req;
  assign instr_addr_o = r_addr;
  assign dec_req_o    = r_dec_req;
  assign dec_pc_o     = r_fifo_pc[0];
  assign dec_instr_o  = r_fifo_instr[0];

endmodule
